// File: rtl/serial_full_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester drives start and operands; the subtractor drives status and result.
// Build option SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_full_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Requester side
  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  // Subtractor side
  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: start at edge E0, done pulses in the cycle after edge E0+WIDTH.
// Backpressure: start is ignored while busy; SERIAL_SUB_OVF_EN adds ovf.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_full_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  // The minuend register doubles as the result shift register: as each
  // minuend bit leaves at the LSB, the difference bit enters at the MSB.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             brw_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs and the running borrow
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  end

  generate
    if (WIDTH == 1) begin : g_w1
      assign res_next = d;
    end else begin : g_wn
      assign res_next = {d, a_sh[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM, operand shifting and registered result/status
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      bus.ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            brw      <= bus.bin;
            cnt      <= '0;
            state    <= SHIFT;
            bus.busy <= 1'b1;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh <= res_next;
          b_sh <= b_sh >> 1;
          brw  <= brw_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.diff <= res_next;
            bus.bout <= brw_next;
`ifdef SERIAL_SUB_OVF_EN
            // brw is the borrow into the MSB cell on this final edge
            bus.ovf  <= brw ^ brw_next;
`endif
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor at WIDTH=8.
// Table-driven vectors plus lockout, reset-abort and random sequences.
// Expected results are queued at start and checked when done pulses.
module tb_serial_full_subtractor;
  localparam int W = 8;

  logic clk;
  logic rst;

  serial_full_subtractor_if #(.WIDTH(W)) bus ();

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    exp_t         e;
  } vec_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_diff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t e;
    int   r;
    e.diff = av - bv - W'(bi);
    e.bout = ({1'b0, av} < ({1'b0, bv} + {{W{1'b0}}, bi}));
    r      = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    e.ovf  = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.diff));
        chk("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input exp_t e, input bit lock);
    int done_at;
    int busy_cnt;
    int pulses;
    bit held;
    sb.push_back(e);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = bi;
    bus.start = 1'b1;
    @(posedge clk);  // E0
    done_at  = -1;
    busy_cnt = 0;
    pulses   = 0;
    held     = 1'b1;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);  // after edge E0+c
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      if (c < W && bus.diff !== last_diff) held = 1'b0;
      if (lock && (c == 2 || c == W)) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.bin   = 1'b1;
      end
    end
    chk("done_latency", 32'(done_at), 32'(W));
    chk("busy_cycles", 32'(busy_cnt), 32'(W + 1));
    chk("done_pulses", 32'(pulses), 32'd1);
    chk("diff_held", 32'(held), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    last_diff = e.diff;
  endtask

  initial begin
    vec_t tbl[6];
    int   pulses;
    tbl[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, e: '{diff: 8'h23, bout: 1'b0, ovf: 1'b0}};
    tbl[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, e: '{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}};
    tbl[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, e: '{diff: 8'h7F, bout: 1'b0, ovf: 1'b1}};
    tbl[3] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, e: '{diff: 8'h80, bout: 1'b1, ovf: 1'b1}};
    tbl[4] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, e: '{diff: 8'h00, bout: 1'b0, ovf: 1'b0}};
    tbl[5] = '{a: 8'h00, b: 8'h00, bin: 1'b1, e: '{diff: 8'hFF, bout: 1'b1, ovf: 1'b0}};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    last_diff = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].e, 1'b0);
    end

    // Busy lockout: restarts during SHIFT and DONE must be ignored
    run_op(8'h05, 8'h03, 1'b0, '{diff: 8'h02, bout: 1'b0, ovf: 1'b0}, 1'b1);
    repeat (3) @(negedge clk);
    chk("lock_idle_busy", 32'(bus.busy), 32'd0);
    chk("lock_diff_kept", 32'(bus.diff), 32'h02);

    // Reset mid-operation after a completed op
    run_op(8'h35, 8'h12, 1'b0, '{diff: 8'h23, bout: 1'b0, ovf: 1'b0}, 1'b0);
    @(negedge clk);
    bus.a     = 8'h99;
    bus.b     = 8'h11;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);  // E0
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;       // sampled at edge E0+4
    @(negedge clk);
    rst = 1'b0;
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    last_diff = '0;
    pulses = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(8'h09, 8'h04, 1'b0, model(8'h09, 8'h04, 1'b0), 1'b0);
    chk("fresh_diff", 32'(bus.diff), 32'h05);

    // Random operands against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbi, model(ra, rb, rbi), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
